mem_req_arbiter_2port: RTL and testbench

- Shares one memory request/response port between the processor's instruction-fetch path (port 0, imem) and data path (port 1, dmem).
- Arbitrates requests round-robin and forwards the winner's message unmodified.
- Records the winner's ID in an in-order tag FIFO so that each response is routed back to the right requester.
- Sits between the processor's imem/dmem ports and a single-ported memory or cache; the downstream memory must respond in request order.

---
 rtl/mem_req_arbiter_2port_pkg.sv | 39 +++
 rtl/mem_arb_tag_fifo.sv | 74 +++++++
 rtl/mem_req_arbiter_2port.sv | 150 +++++++++++++++
 tb/tb_mem_req_arbiter_2port.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_2port_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_arbiter_2port_pkg
//  Purpose  : Shared definitions for the two-port memory request arbiter:
//             requester IDs, reset level and the grant-selection helper.
//  Revision : 1.0  initial release
// ============================================================================
package mem_req_arbiter_2port_pkg;

    // Requester identifier as stored in the tag FIFO.
    typedef logic arb_id_t;

    localparam arb_id_t ARB_ID_IMEM  = 1'b0;
    localparam arb_id_t ARB_ID_DMEM  = 1'b1;

    // Level of the reset input that holds the block in reset.
    localparam logic    RESET_ACTIVE = 1'b0;

    // Picks the granted requester. A lone requester always wins; on a tie
    // (or when nobody asks) the caller-supplied preferred ID is returned, so
    // the tie policy (round-robin or fixed) lives entirely in the caller.
    function automatic arb_id_t arb_grant(
        input logic    i_val0,
        input logic    i_val1,
        input arb_id_t i_tie_winner
    );
        arb_id_t w_id;
        if (i_val0 && !i_val1) begin
            w_id = ARB_ID_IMEM;
        end else if (!i_val0 && i_val1) begin
            w_id = ARB_ID_DMEM;
        end else begin
            w_id = i_tie_winner;
        end
        return w_id;
    endfunction

endpackage : mem_req_arbiter_2port_pkg
`default_nettype wire

// File: rtl/mem_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_tag_fifo
//  Purpose  : In-order FIFO of 1-bit requester IDs. One entry is pushed per
//             accepted memory request and popped per delivered response, so
//             the head always names the owner of the next response.
//  Ports    : clk        - clock, all state changes on posedge
//             reset      - synchronous, active-low
//             i_enq      - push i_enq_data (caller never pushes when full
//                          unless it pops in the same cycle)
//             i_enq_data - requester ID to push
//             i_deq      - pop the head entry (caller never pops when empty)
//             o_full     - DEPTH entries held
//             o_empty    - no entries held
//             o_head     - ID at the read pointer
//             o_count    - number of entries held (0..DEPTH)
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb_tag_fifo
    import mem_req_arbiter_2port_pkg::*;
#(
    parameter int DEPTH = 4     // power of two, at least 2
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_enq,
    input  logic                       i_enq_data,
    input  logic                       i_deq,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]   r_mem;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_enq) begin
                r_mem[r_wr_ptr] <= i_enq_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (i_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged,
            // which is what lets a full FIFO accept a tag while draining.
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : mem_arb_tag_fifo
`default_nettype wire

// File: rtl/mem_req_arbiter_2port.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_arbiter_2port
//  Purpose  : Shares one val/rdy memory port between the instruction-fetch
//             requester (port 0, imem) and the data requester (port 1, dmem).
//             Requests are arbitrated and forwarded combinationally; the
//             winner's ID is queued so in-order responses are steered back
//             to the requester that issued them.
//  Ports    : clk, reset (synchronous, active-low)
//             req0_*  / resp0_*   imem request in / response out
//             req1_*  / resp1_*   dmem request in / response out
//             memreq_* / memresp_* shared downstream port (in-order memory)
//  Config   : `define MEM_REQ_ARBITER_DMEM_PRIORITY_EN selects fixed
//             priority (dmem wins every tie); otherwise ties alternate
//             round-robin, imem first after reset.
//  Revision : 1.0  initial release
// ============================================================================
module mem_req_arbiter_2port
    import mem_req_arbiter_2port_pkg::*;
#(
    // Defaults match VC_MEM_REQ_MSG_NBITS(8,32,32) and
    // VC_MEM_RESP_MSG_NBITS(8,32).
    parameter int REQ_NBITS       = 77,
    parameter int RESP_NBITS      = 47,
    parameter int MAX_OUTSTANDING = 4     // power of two, at least 2
)(
    input  logic                  clk,
    input  logic                  reset,

    input  logic [REQ_NBITS-1:0]  req0_msg,
    input  logic                  req0_val,
    output logic                  req0_rdy,

    input  logic [REQ_NBITS-1:0]  req1_msg,
    input  logic                  req1_val,
    output logic                  req1_rdy,

    output logic [RESP_NBITS-1:0] resp0_msg,
    output logic                  resp0_val,
    input  logic                  resp0_rdy,

    output logic [RESP_NBITS-1:0] resp1_msg,
    output logic                  resp1_val,
    input  logic                  resp1_rdy,

    output logic [REQ_NBITS-1:0]  memreq_msg,
    output logic                  memreq_val,
    input  logic                  memreq_rdy,

    input  logic [RESP_NBITS-1:0] memresp_msg,
    input  logic                  memresp_val,
    output logic                  memresp_rdy
);

    // ------------------------------------------------------------------
    // Internal nets
    // ------------------------------------------------------------------
    logic                               w_run;
    arb_id_t                            w_tie_winner;
    arb_id_t                            w_grant;
    logic                               w_any_req;
    logic                               w_can_issue;
    logic                               w_issue_ok;
    logic                               w_enq_fire;
    logic                               w_deq_fire;
    logic                               w_has_tag;
    logic                               w_head_rdy;
    logic                               w_tag_full;
    logic                               w_tag_empty;
    arb_id_t                            w_tag_head;
    // Occupancy is covered by full/empty here; the count is left dangling.
    logic [$clog2(MAX_OUTSTANDING+1)-1:0] w_tag_count_unused;

    // Every val/rdy output is held low while reset is asserted.
    assign w_run = (reset != RESET_ACTIVE);

    // ------------------------------------------------------------------
    // Tie policy
    // ------------------------------------------------------------------
`ifdef MEM_REQ_ARBITER_DMEM_PRIORITY_EN
    assign w_tie_winner = ARB_ID_DMEM;
`else
    logic r_last_grant;

    // Only a completed handshake moves the pointer, so a winner stalled by
    // memreq_rdy=0 keeps its grant until it is accepted.
    always_ff @(posedge clk) begin
        if (reset == RESET_ACTIVE) begin
            r_last_grant <= ARB_ID_DMEM;     // imem wins the first tie
        end else if (w_enq_fire) begin
            r_last_grant <= w_grant;
        end
    end

    assign w_tie_winner = ~r_last_grant;
`endif

    assign w_grant   = arb_grant(req0_val, req1_val, w_tie_winner);
    assign w_any_req = req0_val || req1_val;

    // ------------------------------------------------------------------
    // Response routing (head of the tag FIFO owns memresp)
    // ------------------------------------------------------------------
    assign w_has_tag   = ~w_tag_empty;
    assign w_head_rdy  = (w_tag_head == ARB_ID_IMEM) ? resp0_rdy : resp1_rdy;

    // With no tag outstanding a response has no owner: hold it off.
    assign memresp_rdy = w_run && w_has_tag && w_head_rdy;
    assign w_deq_fire  = memresp_val && memresp_rdy;

    assign resp0_val   = w_run && memresp_val && w_has_tag && (w_tag_head == ARB_ID_IMEM);
    assign resp1_val   = w_run && memresp_val && w_has_tag && (w_tag_head == ARB_ID_DMEM);
    assign resp0_msg   = memresp_msg;
    assign resp1_msg   = memresp_msg;

    // ------------------------------------------------------------------
    // Request forwarding
    // ------------------------------------------------------------------
    // A slot freed by a same-cycle response is reusable immediately.
    assign w_can_issue = ~w_tag_full || w_deq_fire;

    assign memreq_val  = w_run && w_can_issue && w_any_req;
    assign memreq_msg  = !memreq_val               ? '0       :
                         (w_grant == ARB_ID_DMEM)  ? req1_msg : req0_msg;

    assign w_issue_ok  = w_run && w_can_issue && memreq_rdy;
    assign req0_rdy    = w_issue_ok && (w_grant == ARB_ID_IMEM);
    assign req1_rdy    = w_issue_ok && (w_grant == ARB_ID_DMEM);

    assign w_enq_fire  = memreq_val && memreq_rdy;

    // ------------------------------------------------------------------
    // In-order tag FIFO
    // ------------------------------------------------------------------
    mem_arb_tag_fifo #(
        .DEPTH      (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_enq      (w_enq_fire),
        .i_enq_data (w_grant),
        .i_deq      (w_deq_fire),
        .o_full     (w_tag_full),
        .o_empty    (w_tag_empty),
        .o_head     (w_tag_head),
        .o_count    (w_tag_count_unused)
    );

endmodule : mem_req_arbiter_2port
`default_nettype wire

// File: tb/tb_mem_req_arbiter_2port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_req_arbiter_2port
//  Purpose  : Self-checking bench for mem_req_arbiter_2port. Directed
//             scenarios plus a randomized run compared against a queue-based
//             reference model of the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_req_arbiter_2port;

    localparam int REQ_NBITS  = 77;
    localparam int RESP_NBITS = 47;
    localparam int MAX_OUT    = 4;
`ifdef MEM_REQ_ARBITER_DMEM_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [REQ_NBITS-1:0]  req0_msg, req1_msg, memreq_msg;
    logic                  req0_val, req0_rdy, req1_val, req1_rdy;
    logic [RESP_NBITS-1:0] resp0_msg, resp1_msg, memresp_msg;
    logic                  resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic                  memreq_val, memreq_rdy, memresp_val, memresp_rdy;

    always #5 clk = ~clk;

    mem_req_arbiter_2port #(
        .REQ_NBITS       (REQ_NBITS),
        .RESP_NBITS      (RESP_NBITS),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_msg    (req0_msg),
        .req0_val    (req0_val),
        .req0_rdy    (req0_rdy),
        .req1_msg    (req1_msg),
        .req1_val    (req1_val),
        .req1_rdy    (req1_rdy),
        .resp0_msg   (resp0_msg),
        .resp0_val   (resp0_val),
        .resp0_rdy   (resp0_rdy),
        .resp1_msg   (resp1_msg),
        .resp1_val   (resp1_val),
        .resp1_rdy   (resp1_rdy),
        .memreq_msg  (memreq_msg),
        .memreq_val  (memreq_val),
        .memreq_rdy  (memreq_rdy),
        .memresp_msg (memresp_msg),
        .memresp_val (memresp_val),
        .memresp_rdy (memresp_rdy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Outstanding requests are a plain queue of requester IDs.
    bit                    m_q[$];
    bit                    m_last = 1'b1;
    bit                    e_grant, e_enq, e_deq;
    logic                  e_memreq_val, e_req0_rdy, e_req1_rdy;
    logic                  e_resp0_val, e_resp1_val, e_memresp_rdy;
    logic [REQ_NBITS-1:0]  e_memreq_msg;

    task automatic model_eval();
        bit run, can, head;
        int cnt;
        run  = (reset === 1'b1);
        cnt  = m_q.size();
        head = (cnt != 0) ? m_q[0] : 1'b0;
        e_memresp_rdy = run && (cnt != 0) && (head ? resp1_rdy : resp0_rdy);
        e_deq         = memresp_val && e_memresp_rdy;
        can           = (cnt < MAX_OUT) || e_deq;
        if (req0_val && req1_val) e_grant = PRIO ? 1'b1 : !m_last;
        else                      e_grant = req1_val;
        e_memreq_val  = run && can && (req0_val || req1_val);
        e_memreq_msg  = e_memreq_val ? (e_grant ? req1_msg : req0_msg) : '0;
        e_req0_rdy    = run && can && memreq_rdy && !e_grant;
        e_req1_rdy    = run && can && memreq_rdy &&  e_grant;
        e_resp0_val   = run && memresp_val && (cnt != 0) && !head;
        e_resp1_val   = run && memresp_val && (cnt != 0) &&  head;
        e_enq         = e_memreq_val && memreq_rdy;
    endtask

    // One clock: model follows the handshakes implied by current inputs.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (reset !== 1'b1) begin
            m_q.delete();
            m_last = 1'b1;
        end else begin
            if (e_deq) void'(m_q.pop_front());
            if (e_enq) begin
                m_q.push_back(e_grant);
                m_last = e_grant;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req0_msg = '0; req0_val = 0; req1_msg = '0; req1_val = 0;
        resp0_rdy = 0; resp1_rdy = 0; memreq_rdy = 0;
        memresp_msg = '0; memresp_val = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [REQ_NBITS-1:0] mk_req(input logic [31:0] addr, input logic [31:0] data);
        return {3'd0, 8'd0, addr, 2'd0, data};
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        req0_val = 1; req1_val = 1; memreq_rdy = 1;
        memresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (req0_rdy !== 1'b0)    begin n_fail++; $display("FAIL reset_req0_rdy: got %b want 0", req0_rdy); end
            n_checks++; if (req1_rdy !== 1'b0)    begin n_fail++; $display("FAIL reset_req1_rdy: got %b want 0", req1_rdy); end
            n_checks++; if (memreq_val !== 1'b0)  begin n_fail++; $display("FAIL reset_memreq_val: got %b want 0", memreq_val); end
            n_checks++; if (resp0_val !== 1'b0)   begin n_fail++; $display("FAIL reset_resp0_val: got %b want 0", resp0_val); end
            n_checks++; if (resp1_val !== 1'b0)   begin n_fail++; $display("FAIL reset_resp1_val: got %b want 0", resp1_val); end
            n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_memresp_rdy: got %b want 0", memresp_rdy); end
            tick();
        end
        do_reset();
    endtask

    task automatic test_single_read();
        logic [REQ_NBITS-1:0]  rq;
        logic [RESP_NBITS-1:0] rs;
        do_reset();
        rq = mk_req(32'h0000_1000, 32'h0);
        rs = {3'd0, 8'd0, 2'd0, 2'd0, 32'hdeadbeef};
        req0_msg = rq; req0_val = 1; memreq_rdy = 1;
        #1;
        n_checks++; if (memreq_val !== 1'b1) begin n_fail++; $display("FAIL single_memreq_val: got %b want 1", memreq_val); end
        n_checks++; if (memreq_msg !== rq)   begin n_fail++; $display("FAIL single_memreq_msg: got %h want %h", memreq_msg, rq); end
        n_checks++; if (req0_rdy !== 1'b1)   begin n_fail++; $display("FAIL single_req0_rdy: got %b want 1", req0_rdy); end
        tick();
        req0_val = 0; memresp_val = 1; memresp_msg = rs; resp0_rdy = 1; resp1_rdy = 1;
        #1;
        n_checks++; if (resp0_val !== 1'b1)   begin n_fail++; $display("FAIL single_resp0_val: got %b want 1", resp0_val); end
        n_checks++; if (resp0_msg !== rs)     begin n_fail++; $display("FAIL single_resp0_msg: got %h want %h", resp0_msg, rs); end
        n_checks++; if (resp1_val !== 1'b0)   begin n_fail++; $display("FAIL single_resp1_val: got %b want 0", resp1_val); end
        n_checks++; if (memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL single_memresp_rdy: got %b want 1", memresp_rdy); end
        tick();
        #1;  // FIFO empty again: response is no longer accepted
        n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL single_drained: got memresp_rdy %b want 0", memresp_rdy); end
        n_checks++; if (resp0_val !== 1'b0)   begin n_fail++; $display("FAIL single_drained_resp0_val: got %b want 0", resp0_val); end
        clear_inputs();
    endtask

    task automatic test_alternation();
        logic [REQ_NBITS-1:0] m0, m1;
        bit exp;
        do_reset();
        m0 = mk_req(32'hA000_0000, 32'h1111_1111);
        m1 = mk_req(32'hB000_0000, 32'h2222_2222);
        req0_msg = m0; req1_msg = m1; req0_val = 1; req1_val = 1; memreq_rdy = 1;
        memresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            exp = PRIO ? 1'b1 : 1'(i % 2);
            #1;
            n_checks++; if (memreq_msg !== (exp ? m1 : m0)) begin n_fail++; $display("FAIL alt_grant[%0d]: got msg %h want %h", i, memreq_msg, exp ? m1 : m0); end
            n_checks++; if ({req1_rdy, req0_rdy} !== (exp ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL alt_rdy[%0d]: got %b%b want port %0d", i, req1_rdy, req0_rdy, exp); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        req0_val = 1; req0_msg = mk_req(32'h40, 32'h0); memreq_rdy = 1;
        for (int i = 0; i < MAX_OUT; i++) tick();
        #1;
        n_checks++; if (req0_rdy !== 1'b0)   begin n_fail++; $display("FAIL full_req0_rdy: got %b want 0", req0_rdy); end
        n_checks++; if (memreq_val !== 1'b0) begin n_fail++; $display("FAIL full_memreq_val: got %b want 0", memreq_val); end
        memresp_val = 1; resp0_rdy = 1; memresp_msg = 47'h12345;
        #1;
        n_checks++; if (memresp_rdy !== 1'b1) begin n_fail++; $display("FAIL full_deq_rdy: got %b want 1", memresp_rdy); end
        n_checks++; if (req0_rdy !== 1'b1)    begin n_fail++; $display("FAIL full_enq_with_deq: got %b want 1", req0_rdy); end
        n_checks++; if (memreq_val !== 1'b1)  begin n_fail++; $display("FAIL full_memreq_val_with_deq: got %b want 1", memreq_val); end
        tick();
        memresp_val = 0;
        #1;  // count stayed at the limit
        n_checks++; if (req0_rdy !== 1'b0) begin n_fail++; $display("FAIL full_after_swap: got req0_rdy %b want 0", req0_rdy); end
        clear_inputs();
    endtask

    task automatic test_resp_stall();
        bit                    order[4];
        logic [RESP_NBITS-1:0] data[4];
        int k, stall;
        bit p;
        do_reset();
        order = '{1'b0, 1'b1, 1'b1, 1'b0};
        memreq_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            req0_val = !order[i]; req1_val = order[i];
            req0_msg = mk_req(32'h100 + 32'(i), 32'h0); req1_msg = mk_req(32'h200 + 32'(i), 32'h0);
            data[i] = RESP_NBITS'($urandom());
            #1;
            n_checks++; if (memreq_val !== 1'b1) begin n_fail++; $display("FAIL stall_issue[%0d]: got memreq_val %b want 1", i, memreq_val); end
            tick();
        end
        req0_val = 0; req1_val = 0;
        k = 0; stall = 3;
        for (int c = 0; c < 12 && k < 4; c++) begin
            p = order[k];
            memresp_val = 1; memresp_msg = data[k];
            if (p && stall > 0) begin
                resp0_rdy = 1; resp1_rdy = 0;
                #1;
                n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_memresp_rdy: got %b want 0", memresp_rdy); end
                n_checks++; if (resp1_val !== 1'b1)   begin n_fail++; $display("FAIL stall_resp1_val: got %b want 1", resp1_val); end
                stall--;
            end else begin
                resp0_rdy = 1; resp1_rdy = 1;
                #1;
                n_checks++; if ({resp1_val, resp0_val} !== (p ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL order_route[%0d]: got %b%b want port %0d", k, resp1_val, resp0_val, p); end
                n_checks++; if ((p ? resp1_msg : resp0_msg) !== data[k]) begin n_fail++; $display("FAIL order_data[%0d]: got %h want %h", k, p ? resp1_msg : resp0_msg, data[k]); end
                k++;
            end
            tick();
        end
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL stall_timeout: delivered %0d want 4", k); end
        clear_inputs();
    endtask

    task automatic test_spurious();
        do_reset();
        memresp_val = 1; memresp_msg = 47'h7; resp0_rdy = 1; resp1_rdy = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL spurious_rdy: got %b want 0", memresp_rdy); end
            n_checks++; if ({resp1_val, resp0_val} !== 2'b00) begin n_fail++; $display("FAIL spurious_val: got %b%b want 00", resp1_val, resp0_val); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [REQ_NBITS-1:0] m0, m1;
        do_reset();
        m0 = mk_req(32'hC0, 32'h5); m1 = mk_req(32'hD0, 32'h6);
        req0_msg = m0; req1_msg = m1; memreq_rdy = 1;
        req1_val = 1; tick(); req1_val = 0;
        req0_val = 1; tick();            // last winner before reset is imem
        reset = 0; req0_val = 1; req1_val = 1;
        memresp_val = 1; resp0_rdy = 1; resp1_rdy = 1;
        #1;
        n_checks++; if ({req0_rdy, req1_rdy, memreq_val, resp0_val, resp1_val, memresp_rdy} !== 6'b0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b%b%b%b%b%b want 000000", req0_rdy, req1_rdy, memreq_val, resp0_val, resp1_val, memresp_rdy); end
        tick();
        reset = 1;
        #1;
        n_checks++; if (memresp_rdy !== 1'b0) begin n_fail++; $display("FAIL midreset_tags_dropped: got memresp_rdy %b want 0", memresp_rdy); end
        n_checks++; if (resp0_val !== 1'b0)   begin n_fail++; $display("FAIL midreset_resp0_val: got %b want 0", resp0_val); end
        n_checks++; if (memreq_msg !== (PRIO ? m1 : m0)) begin n_fail++; $display("FAIL midreset_tie: got %h want %h", memreq_msg, PRIO ? m1 : m0); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reset       = ($urandom_range(0, 79) != 0);
            req0_val    = 1'($urandom());
            req1_val    = 1'($urandom());
            req0_msg    = REQ_NBITS'({$urandom(), $urandom(), $urandom()});
            req1_msg    = REQ_NBITS'({$urandom(), $urandom(), $urandom()});
            memreq_rdy  = ($urandom_range(0, 3) != 0);
            memresp_val = 1'($urandom());
            memresp_msg = RESP_NBITS'({$urandom(), $urandom()});
            resp0_rdy   = ($urandom_range(0, 3) != 0);
            resp1_rdy   = ($urandom_range(0, 3) != 0);
            #1;
            model_eval();
            n_checks++; if (memreq_val !== e_memreq_val)   begin n_fail++; $display("FAIL rnd_memreq_val @%0d: got %b want %b", c, memreq_val, e_memreq_val); end
            n_checks++; if (memreq_msg !== e_memreq_msg)   begin n_fail++; $display("FAIL rnd_memreq_msg @%0d: got %h want %h", c, memreq_msg, e_memreq_msg); end
            if (req0_val) begin
                n_checks++; if (req0_rdy !== e_req0_rdy)   begin n_fail++; $display("FAIL rnd_req0_rdy @%0d: got %b want %b", c, req0_rdy, e_req0_rdy); end
            end
            if (req1_val) begin
                n_checks++; if (req1_rdy !== e_req1_rdy)   begin n_fail++; $display("FAIL rnd_req1_rdy @%0d: got %b want %b", c, req1_rdy, e_req1_rdy); end
            end
            n_checks++; if (resp0_val !== e_resp0_val)     begin n_fail++; $display("FAIL rnd_resp0_val @%0d: got %b want %b", c, resp0_val, e_resp0_val); end
            n_checks++; if (resp1_val !== e_resp1_val)     begin n_fail++; $display("FAIL rnd_resp1_val @%0d: got %b want %b", c, resp1_val, e_resp1_val); end
            n_checks++; if (memresp_rdy !== e_memresp_rdy) begin n_fail++; $display("FAIL rnd_memresp_rdy @%0d: got %b want %b", c, memresp_rdy, e_memresp_rdy); end
            n_checks++; if (resp0_msg !== memresp_msg || resp1_msg !== memresp_msg) begin
                n_fail++; $display("FAIL rnd_resp_msg @%0d: got %h/%h want %h", c, resp0_msg, resp1_msg, memresp_msg); end
            tick();
        end
        clear_inputs();
        reset = 1'b1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_single_read();
        test_alternation();
        test_full();
        test_resp_stall();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_req_arbiter_2port
`default_nettype wire
